ioctl_byte_tx: RTL and testbench

- Producer end of the ioctl download stream that rom_loader and the SDRAM/BRAM loading path consume.
- Accepts 32-bit words from the platform data-bridge side and serializes them into byte-wide ioctl_wr strobes with a matching ioctl_addr.
- Honours the ioctl_wait backpressure raised by rom_loader while SDRAM writes are pending.
- Frames each transfer with ioctl_download and ioctl_index.

---
 rtl/ioctl_byte_tx.sv | 142 ++++++++++++++
 tb/tb_ioctl_byte_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_byte_tx.sv
// Serializes 32-bit big-endian words into byte-wide ioctl_wr strobes for the ioctl download
// stream, honouring ioctl_wait backpressure and a minimum idle gap between strobes.
module ioctl_byte_tx #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned WR_GAP = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dl_start_i,
    input  logic [15:0]       dl_index_i,
    input  logic              dl_end_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [2:0]        wr_len_i,
    output logic              ioctl_download_o,
    output logic [15:0]       ioctl_index_o,
    output logic              ioctl_wr_o,
    output logic [ADDR_W-1:0] ioctl_addr_o,
    output logic [7:0]        ioctl_data_o,
    input  logic              ioctl_wait_i,
    output logic              busy_o
);

    // GAP always occupies at least one cycle so ioctl_wr can never be high back to back.
    localparam int unsigned GapCycles = (WR_GAP == 0) ? 1 : WR_GAP;
    localparam logic [3:0]  GapLast   = 4'(GapCycles - 1);

    typedef enum logic [1:0] {StIdle, StOpen, StArm, StGap} state_e;

    state_e            state_q;
    logic              download_q;
    logic [15:0]       index_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic [2:0]        cnt_q;
    logic [3:0]        gap_q;
    logic              end_pend_q;

    logic [2:0] len_clamp;
    logic [7:0] byte_sel;
    logic       more_bytes;

    always_comb begin
        len_clamp  = (wr_len_i > 3'd4) ? 3'd4 : wr_len_i;
        more_bytes = (cnt_q + 3'd1) < len_q;
        byte_sel   = word_q[31:24];
        case (cnt_q[1:0])
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            download_q <= 1'b0;
            index_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            word_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            end_pend_q <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dl_start_i) begin
                        state_q    <= StOpen;
                        download_q <= 1'b1;
                        index_q    <= dl_index_i;
                        end_pend_q <= dl_end_i;
                    end
                end
                StOpen: begin
                    // A close request beats a word offered in the same cycle.
                    if (dl_end_i || end_pend_q) begin
                        state_q    <= StIdle;
                        download_q <= 1'b0;
                        end_pend_q <= 1'b0;
                    end else if (wr_valid_i) begin
                        word_q  <= wr_data_i;
                        base_q  <= wr_addr_i;
                        len_q   <= len_clamp;
                        cnt_q   <= '0;
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (dl_end_i) begin
                        end_pend_q <= 1'b1;
                    end
                    if (len_q == 3'd0) begin
                        state_q <= StOpen;
                    end else if (!ioctl_wait_i) begin
                        wr_q    <= 1'b1;
                        addr_q  <= base_q + ADDR_W'(cnt_q);
                        data_q  <= byte_sel;
                        gap_q   <= '0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (dl_end_i) begin
                        end_pend_q <= 1'b1;
                    end
                    if (gap_q == GapLast) begin
                        if (more_bytes) begin
                            cnt_q   <= cnt_q + 3'd1;
                            state_q <= StArm;
                        end else begin
                            state_q <= StOpen;
                        end
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_ready_o       = (state_q == StOpen);
    assign busy_o           = (state_q == StArm) || (state_q == StGap);
    assign ioctl_download_o = download_q;
    assign ioctl_index_o    = index_q;
    assign ioctl_wr_o       = wr_q;
    assign ioctl_addr_o     = addr_q;
    assign ioctl_data_o     = data_q;

endmodule

// File: tb/tb_ioctl_byte_tx.sv
// Bench for ioctl_byte_tx: directed steps on a WR_GAP=3 instance plus randomized word sweeps on
// WR_GAP=0 and WR_GAP=15 instances, checked against a byte-stream model of the download.
module tb_ioctl_byte_tx;

    typedef struct {
        int          inst;
        int          cyc;
        logic [24:0] addr;
        logic [7:0]  data;
    } strobe_t;

    logic        clk;
    logic        rst;
    logic        dl_start [3];
    logic [15:0] dl_index [3];
    logic        dl_end   [3];
    logic        wr_valid [3];
    logic        wr_ready [3];
    logic [24:0] wr_addr  [3];
    logic [31:0] wr_data  [3];
    logic [2:0]  wr_len   [3];
    logic        dl_on    [3];
    logic [15:0] idx      [3];
    logic        io_wr    [3];
    logic [24:0] io_addr  [3];
    logic [7:0]  io_data  [3];
    logic        io_wait  [3];
    logic        busy     [3];

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc   = 0;
    logic    prev_wr   [3];
    logic    wait_edge [3];
    strobe_t obs_q[$];
    strobe_t exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ioctl_byte_tx #(
            .ADDR_W(25),
            .WR_GAP((g == 0) ? 3 : (g == 1) ? 0 : 15)
        ) u_dut (
            .clk_i           (clk),
            .reset_i         (rst),
            .dl_start_i      (dl_start[g]),
            .dl_index_i      (dl_index[g]),
            .dl_end_i        (dl_end[g]),
            .wr_valid_i      (wr_valid[g]),
            .wr_ready_o      (wr_ready[g]),
            .wr_addr_i       (wr_addr[g]),
            .wr_data_i       (wr_data[g]),
            .wr_len_i        (wr_len[g]),
            .ioctl_download_o(dl_on[g]),
            .ioctl_index_o   (idx[g]),
            .ioctl_wr_o      (io_wr[g]),
            .ioctl_addr_o    (io_addr[g]),
            .ioctl_data_o    (io_data[g]),
            .ioctl_wait_i    (io_wait[g]),
            .busy_o          (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Strobe log and stream rules, sampled mid-cycle; cyc is the edge that registered the strobe.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (io_wr[i] === 1'b1) begin
                chk($sformatf("wr_back_to_back%0d", i), 32'(prev_wr[i]), 32'd0);
                chk($sformatf("wr_after_wait%0d", i), 32'(wait_edge[i]), 32'd0);
                obs_q.push_back(strobe_t'{inst: i, cyc: cyc, addr: io_addr[i], data: io_data[i]});
            end
            prev_wr[i]   <= io_wr[i];
            wait_edge[i] <= io_wait[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bytes of one word: big-endian, length clamped to 4, address modulo 2^25.
    task automatic push_word(input int i, input logic [24:0] a, input logic [31:0] d,
                             input logic [2:0] l, input int acc, input int s, input int max_b);
        int n;
        n = (l > 3'd4) ? 4 : int'(l);
        if (n > max_b) n = max_b;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(strobe_t'{inst: i, cyc: (s > 0) ? acc + 1 + k * s : -1,
                                      addr: a + 25'(k), data: 8'(d >> (24 - 8 * k))});
        end
    endtask

    task automatic compare_all(input string tag);
        strobe_t o;
        strobe_t e;
        int      k;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        k = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("%s_inst%0d", tag, k), 32'(o.inst), 32'(e.inst));
            chk($sformatf("%s_addr%0d", tag, k), 32'(o.addr), 32'(e.addr));
            chk($sformatf("%s_data%0d", tag, k), 32'(o.data), 32'(e.data));
            if (e.cyc >= 0) chk($sformatf("%s_cyc%0d", tag, k), 32'(o.cyc), 32'(e.cyc));
            k++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_word(input int i, input logic [24:0] a, input logic [31:0] d,
                             input logic [2:0] l, output int acc);
        logic rdy;
        wr_addr[i]  = a;
        wr_data[i]  = d;
        wr_len[i]   = l;
        wr_valid[i] = 1'b1;
        acc = -1;
        for (int k = 0; k < 400 && acc < 0; k++) begin
            rdy = wr_ready[i];
            tick();
            if (rdy) acc = cyc;
        end
        wr_valid[i] = 1'b0;
        chk("accept_timeout", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_ready(input int i, output int at);
        for (int k = 0; k < 400 && !wr_ready[i]; k++) tick();
        at = cyc;
        chk("ready_timeout", 32'(wr_ready[i]), 32'd1);
    endtask

    task automatic wait_wr(input int i, input string tag);
        for (int k = 0; k < 100 && !io_wr[i]; k++) tick();
        chk(tag, 32'(io_wr[i]), 32'd1);
    endtask

    task automatic pulse_start(input int i, input logic [15:0] index, input logic with_end);
        dl_start[i] = 1'b1;
        dl_index[i] = index;
        dl_end[i]   = with_end;
        tick();
        dl_start[i] = 1'b0;
        dl_end[i]   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_download"}, 32'(dl_on[0]), 32'd0);
        chk({tag, "_index"}, 32'(idx[0]), 32'd0);
        chk({tag, "_wr"}, 32'(io_wr[0]), 32'd0);
        chk({tag, "_addr"}, 32'(io_addr[0]), 32'd0);
        chk({tag, "_data"}, 32'(io_data[0]), 32'd0);
        chk({tag, "_ready"}, 32'(wr_ready[0]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[0]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          at;
        int          s;
        logic [24:0] ra;
        logic [31:0] rd;
        logic [2:0]  rl;
        logic [15:0] ri;

        for (int i = 0; i < 3; i++) begin
            dl_start[i] = 1'b0; dl_index[i] = '0; dl_end[i] = 1'b0; wr_valid[i] = 1'b0;
            wr_addr[i] = '0; wr_data[i] = '0; wr_len[i] = '0; io_wait[i] = 1'b0;
            prev_wr[i] = 1'b0; wait_edge[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // A word offered while the window is closed is ignored.
        wr_valid[0] = 1'b1;
        tick();
        chk("idle_ready", 32'(wr_ready[0]), 32'd0);
        chk("idle_busy", 32'(busy[0]), 32'd0);
        wr_valid[0] = 1'b0;

        pulse_start(0, 16'h0000, 1'b0);
        chk("open_download", 32'(dl_on[0]), 32'd1);
        chk("open_index", 32'(idx[0]), 32'd0);
        chk("open_ready", 32'(wr_ready[0]), 32'd1);

        send_word(0, 25'h100, 32'hA1B2C3D4, 3'd4, acc);
        push_word(0, 25'h100, 32'hA1B2C3D4, 3'd4, acc, 4, 4);
        wait_ready(0, at);
        chk("basic_ready_cyc", 32'(at), 32'(acc + 16));
        compare_all("basic");

        // Backpressure held for 20 cycles after the second strobe.
        send_word(0, 25'h100, 32'hA1B2C3D4, 3'd4, acc);
        push_word(0, 25'h100, 32'hA1B2C3D4, 3'd4, acc, 0, 4);
        wait_wr(0, "bp_first");
        tick();
        wait_wr(0, "bp_second");
        io_wait[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), 32'(io_wr[0]), 32'd0);
        end
        io_wait[0] = 1'b0;
        tick();
        chk("bp_third_wr", 32'(io_wr[0]), 32'd1);
        chk("bp_third_addr", 32'(io_addr[0]), 32'h102);
        chk("bp_third_data", 32'(io_data[0]), 32'hC3);
        wait_ready(0, at);
        compare_all("bp");

        send_word(0, 25'h180, 32'hFFFFFFFF, 3'd0, acc);
        chk("len0_busy", 32'(busy[0]), 32'd1);
        tick();
        chk("len0_ready", 32'(wr_ready[0]), 32'd1);
        compare_all("len0");

        send_word(0, 25'h400, 32'hDEADBEEF, 3'd6, acc);
        push_word(0, 25'h400, 32'hDEADBEEF, 3'd6, acc, 4, 4);
        wait_ready(0, at);
        compare_all("len6");

        send_word(0, 25'h1FFFFFE, 32'h01020304, 3'd4, acc);
        push_word(0, 25'h1FFFFFE, 32'h01020304, 3'd4, acc, 4, 4);
        wait_ready(0, at);
        compare_all("wrap");

        pulse_start(0, 16'h1234, 1'b0);
        chk("restart_index", 32'(idx[0]), 32'd0);
        chk("restart_download", 32'(dl_on[0]), 32'd1);

        // Close request and word offer in the same cycle.
        wr_addr[0] = 25'h500; wr_data[0] = 32'h55555555; wr_len[0] = 3'd4;
        wr_valid[0] = 1'b1;
        dl_end[0] = 1'b1;
        tick();
        dl_end[0] = 1'b0;
        wr_valid[0] = 1'b0;
        chk("endwin_ready", 32'(wr_ready[0]), 32'd0);
        chk("endwin_download", 32'(dl_on[0]), 32'd0);
        repeat (4) tick();
        compare_all("endwin");

        pulse_start(0, 16'h00A5, 1'b0);
        chk("reopen_index", 32'(idx[0]), 32'hA5);

        // Close requested while byte 0 is in its gap: the word drains, nothing more is taken.
        send_word(0, 25'h200, 32'h11223344, 3'd2, acc);
        push_word(0, 25'h200, 32'h11223344, 3'd2, acc, 4, 4);
        wait_wr(0, "early_first");
        dl_end[0] = 1'b1;
        tick();
        dl_end[0] = 1'b0;
        wr_addr[0] = 25'h300; wr_data[0] = 32'hCAFEF00D; wr_len[0] = 3'd4;
        wr_valid[0] = 1'b1;
        for (int k = 0; k < 100 && dl_on[0]; k++) tick();
        chk("early_download", 32'(dl_on[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("early_ready%0d", k), 32'(wr_ready[0]), 32'd0);
        end
        wr_valid[0] = 1'b0;
        compare_all("early");

        pulse_start(0, 16'h0777, 1'b1);
        chk("startend_download", 32'(dl_on[0]), 32'd1);
        chk("startend_index", 32'(idx[0]), 32'h777);
        tick();
        chk("startend_close", 32'(dl_on[0]), 32'd0);

        // Reset while the third byte is held in ARM by backpressure.
        pulse_start(0, 16'h0055, 1'b0);
        send_word(0, 25'h600, 32'h99AABBCC, 3'd4, acc);
        push_word(0, 25'h600, 32'h99AABBCC, 3'd4, acc, 0, 2);
        wait_wr(0, "rst_first");
        tick();
        wait_wr(0, "rst_second");
        io_wait[0] = 1'b1;
        repeat (5) tick();
        chk("rst_busy_before", 32'(busy[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        io_wait[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rst_quiet%0d", k), 32'(io_wr[0]), 32'd0);
        end
        compare_all("rst_mid");
        pulse_start(0, 16'h0001, 1'b0);
        chk("rst_reopen_index", 32'(idx[0]), 32'd1);
        chk("rst_reopen_download", 32'(dl_on[0]), 32'd1);

        // Randomized back-to-back words on the WR_GAP=0 and WR_GAP=15 instances.
        for (int i = 1; i < 3; i++) begin
            s = (i == 1) ? 2 : 16;
            ri = 16'($urandom);
            pulse_start(i, ri, 1'b0);
            chk($sformatf("sweep%0d_index", i), 32'(idx[i]), 32'(ri));
            for (int w = 0; w < 8; w++) begin
                ra = (w == 3) ? 25'h1FFFFFD : 25'($urandom);
                rd = $urandom;
                rl = 3'($urandom_range(1, 7));
                send_word(i, ra, rd, rl, acc);
                push_word(i, ra, rd, rl, acc, s, 4);
            end
            wait_ready(i, at);
            compare_all($sformatf("sweep%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
